alu_cmd_sched: RTL and testbench

- Upstream command scheduler for alu_design.
- Accepts ALU commands on a valid/ready slave interface and buffers them in a small FIFO.
- Issues one command at a time onto the ALU input ports, waits the command-dependent ALU latency, then captures RES and flags into a result register with a valid/ready master interface.
- Sits between the stimulus/host side and the ALU's CE/INP_VALID/MODE/CMD/CIN/OPA/OPB pins.

---
 rtl/alu_sched_pkg.sv | 36 +++
 rtl/alu_cmd_sched_if.sv | 27 ++
 rtl/alu_cmd_fifo.sv | 63 ++++++
 rtl/alu_cmd_sched.sv | 171 +++++++++++++++++
 tb/tb_alu_cmd_sched.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU command scheduler.
package alu_sched_pkg;

   localparam int OP_W = 8;

   localparam logic [3:0] CMD_MUL_INC = 4'd9;
   localparam logic [3:0] CMD_MUL_SHL = 4'd10;

   localparam int FLAG_COUT  = 0;
   localparam int FLAG_OFLOW = 1;
   localparam int FLAG_G     = 2;
   localparam int FLAG_L     = 3;
   localparam int FLAG_E     = 4;
   localparam int FLAG_ERR   = 5;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_e;

   typedef struct packed {
      logic            mode;
      logic [3:0]      cmd;
      logic            cin;
      logic [1:0]      inp_valid;
      logic [OP_W-1:0] opa;
      logic [OP_W-1:0] opb;
   } cmd_t;

   function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
      return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
   endfunction

endpackage

// File: rtl/alu_cmd_sched_if.sv
// Host-side command (s_*) and result (r_*) handshake bundle of the scheduler.
interface alu_cmd_sched_if #(
   parameter int DW = 8
);
   logic            s_valid;
   logic            s_ready;
   logic            s_mode;
   logic [3:0]      s_cmd;
   logic            s_cin;
   logic [1:0]      s_inp_valid;
   logic [DW-1:0]   s_opa;
   logic [DW-1:0]   s_opb;
   logic            r_valid;
   logic            r_ready;
   logic [2*DW-1:0] r_res;
   logic [5:0]      r_flags;

   modport master (
      output s_valid, s_mode, s_cmd, s_cin, s_inp_valid, s_opa, s_opb, r_ready,
      input  s_ready, r_valid, r_res, r_flags
   );

   modport slave (
      input  s_valid, s_mode, s_cmd, s_cin, s_inp_valid, s_opa, s_opb, r_ready,
      output s_ready, r_valid, r_res, r_flags
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: no bypass, pointers wrap modulo DEPTH (power of two), synchronous active-low reset.
module alu_cmd_fifo
   import alu_sched_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = cmd_t
) (
   input  logic                   clk_sys,
   input  logic                   rst_b,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  T                       wdata_i,
   output T                       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CNT_MAX);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/alu_cmd_sched.sv
// Buffers ALU commands, issues them one at a time with command-dependent latency, and
// hands results back on a valid/ready port. Optional error counter: ALU_SCHED_ERRCNT_EN.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued command
//   ISSUE | CE high, ALU inputs driven, latency counter loaded
//   WAIT  | CE high, inputs held until the ALU latency expires, then RES captured
//   DONE  | result presented on r_*, waiting for r_ready
module alu_cmd_sched
   import alu_sched_pkg::*;
#(
   parameter int DW      = OP_W,
   parameter int DEPTH   = 4,
   parameter int LAT_STD = 1,
   parameter int LAT_MUL = 2
) (
   input  logic            CLK,
   input  logic            RST,
   alu_cmd_sched_if.slave  bus,
   output logic            CE,
   output logic [1:0]      INP_VALID,
   output logic            MODE,
   output logic [3:0]      CMD,
   output logic            CIN,
   output logic [DW-1:0]   OPA,
   output logic [DW-1:0]   OPB,
   input  logic [2*DW-1:0] RES,
   input  logic            COUT,
   input  logic            OFLOW,
   input  logic            G,
   input  logic            L,
   input  logic            E,
   input  logic            ERR,
   output logic [15:0]     err_count
);
   localparam int LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
   localparam int LW      = $clog2(LAT_MAX) + 1;
   localparam logic [LW-1:0] LOAD_STD = LW'(LAT_STD - 1);
   localparam logic [LW-1:0] LOAD_MUL = LW'(LAT_MUL - 1);
   localparam logic [LW-1:0] LAT_ONE  = LW'(1);

   state_e                 state_q;
   cmd_t                   issue_q;
   logic                   ce_q;
   logic [LW-1:0]          lat_cnt_q;
   logic                   r_valid_q;
   logic [2*DW-1:0]        r_res_q;
   logic [5:0]             r_flags_q;

   cmd_t                   push_cmd;
   cmd_t                   fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic [$clog2(DEPTH):0] fifo_cnt;
   logic                   unused_fifo_cnt;
   logic                   res_hs;

   assign push_cmd = '{mode:      bus.s_mode,
                       cmd:       bus.s_cmd,
                       cin:       bus.s_cin,
                       inp_valid: bus.s_inp_valid,
                       opa:       bus.s_opa,
                       opb:       bus.s_opb};

   // Gating with RST keeps s_ready low in the reset cycle itself.
   assign bus.s_ready = RST && !fifo_full;
   assign fifo_push   = bus.s_valid && bus.s_ready;
   assign res_hs      = (state_q == DONE) && bus.r_ready;
   assign fifo_pop    = !fifo_empty && ((state_q == IDLE) || res_hs);
   assign unused_fifo_cnt = ^fifo_cnt;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .T     (cmd_t)
   ) u_fifo (
      .clk_sys (CLK),
      .rst_b   (RST),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (push_cmd),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         issue_q   <= '0;
         ce_q      <= 1'b0;
         lat_cnt_q <= '0;
         r_valid_q <= 1'b0;
         r_res_q   <= '0;
         r_flags_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fifo_pop) begin
                  issue_q <= fifo_head;
                  ce_q    <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               lat_cnt_q <= is_mul(issue_q.mode, issue_q.cmd) ? LOAD_MUL : LOAD_STD;
               state_q   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt_q == '0) begin
                  r_res_q               <= RES;
                  r_flags_q[FLAG_COUT]  <= COUT;
                  r_flags_q[FLAG_OFLOW] <= OFLOW;
                  r_flags_q[FLAG_G]     <= G;
                  r_flags_q[FLAG_L]     <= L;
                  r_flags_q[FLAG_E]     <= E;
                  r_flags_q[FLAG_ERR]   <= ERR;
                  r_valid_q             <= 1'b1;
                  ce_q                  <= 1'b0;
                  state_q               <= DONE;
               end else begin
                  lat_cnt_q <= lat_cnt_q - LAT_ONE;
               end
            end
            DONE: begin
               if (res_hs) begin
                  r_valid_q <= 1'b0;
                  if (fifo_pop) begin
                     issue_q <= fifo_head;
                     ce_q    <= 1'b1;
                     state_q <= ISSUE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign CE          = ce_q;
   assign INP_VALID   = issue_q.inp_valid;
   assign MODE        = issue_q.mode;
   assign CMD         = issue_q.cmd;
   assign CIN         = issue_q.cin;
   assign OPA         = issue_q.opa;
   assign OPB         = issue_q.opb;
   assign bus.r_valid = r_valid_q;
   assign bus.r_res   = r_res_q;
   assign bus.r_flags = r_flags_q;

`ifdef ALU_SCHED_ERRCNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         err_cnt_q <= '0;
      end else if (res_hs && r_flags_q[FLAG_ERR] && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sched.sv
// Bench for alu_cmd_sched: behavioural ALU with pin-level latency plus an in-order result scoreboard.
module tb_alu_cmd_sched;
   localparam int DW = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        CE;
   logic [1:0]  INP_VALID;
   logic        MODE;
   logic [3:0]  CMD;
   logic        CIN;
   logic [7:0]  OPA;
   logic [7:0]  OPB;
   logic [15:0] RES;
   logic        COUT, OFLOW, G, L, E, ERR;
   logic [15:0] err_count;

   always #5 CLK = ~CLK;

   alu_cmd_sched_if #(.DW(DW)) bus ();

   alu_cmd_sched dut (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (bus),
      .CE        (CE),
      .INP_VALID (INP_VALID),
      .MODE      (MODE),
      .CMD       (CMD),
      .CIN       (CIN),
      .OPA       (OPA),
      .OPB       (OPB),
      .RES       (RES),
      .COUT      (COUT),
      .OFLOW     (OFLOW),
      .G         (G),
      .L         (L),
      .E         (E),
      .ERR       (ERR),
      .err_count (err_count)
   );

   typedef struct {
      logic       mode;
      logic [3:0] cmd;
      logic       cin;
      logic [1:0] iv;
      logic [7:0] a;
      logic [7:0] b;
   } tcmd_t;

   // Result as {flags[5:0], res[15:0]}, flags = {ERR,E,L,G,OFLOW,COUT}.
   function automatic logic [21:0] alu_ref(logic mode, logic [3:0] cmd, logic [1:0] iv,
                                           logic [7:0] a, logic [7:0] b);
      logic [15:0] r;
      logic [5:0]  f;
      logic [8:0]  s;
      r = '0;
      f = '0;
      if (iv != 2'b11) begin
         f[5] = 1'b1;
      end else if (mode) begin
         case (cmd)
            4'd0: begin
               s = {1'b0, a} + {1'b0, b};
               r = {7'b0, s};
               f[0] = s[8];
            end
            4'd8: begin
               f[2] = (a > b);
               f[3] = (a < b);
               f[4] = (a == b);
            end
            4'd9:  r = ({8'b0, a} + 16'd1) * ({8'b0, b} + 16'd1);
            4'd10: r = {7'b0, a, 1'b0} * {8'b0, b};
            default: r = {8'b0, a ^ b};
         endcase
      end else begin
         r = {8'b0, a & b};
      end
      return {f, r};
   endfunction

   function automatic int lat_of(logic mode, logic [3:0] cmd);
      return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 2 : 1;
   endfunction

   // ALU pins are only correct in the cycle the latency says; otherwise inverted garbage.
   int          age = 0;
   logic [21:0] alu_now;
   always @(posedge CLK) age <= (CE === 1'b1) ? age + 1 : 0;
   assign alu_now = alu_ref(MODE, CMD, INP_VALID, OPA, OPB);
   assign {ERR, E, L, G, OFLOW, COUT, RES} =
      ((CE === 1'b1) && (age == lat_of(MODE, CMD))) ? alu_now : ~alu_now;

   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   int    got = 0;
   int    hs_cyc[$];
   tcmd_t expq[$];
   bit    acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(output bit accepted);
      tcmd_t       c;
      tcmd_t       x;
      bit          rel;
      logic [15:0] res;
      logic [5:0]  fl;
      logic [21:0] e;
      accepted = (bus.s_valid === 1'b1) && (bus.s_ready === 1'b1);
      rel      = (bus.r_valid === 1'b1) && (bus.r_ready === 1'b1);
      c.mode = bus.s_mode;  c.cmd = bus.s_cmd;  c.cin = bus.s_cin;
      c.iv   = bus.s_inp_valid;  c.a = bus.s_opa;  c.b = bus.s_opb;
      res = bus.r_res;
      fl  = bus.r_flags;
      @(posedge CLK);
      #1;
      cyc++;
      if (rel) begin
         got++;
         hs_cyc.push_back(cyc);
         if (expq.size() == 0) begin
            chk("unexpected_result", {31'b0, rel}, 32'd0);
         end else begin
            x = expq.pop_front();
            e = alu_ref(x.mode, x.cmd, x.iv, x.a, x.b);
            chk("r_res", {16'b0, res}, {16'b0, e[15:0]});
            chk("r_flags", {26'b0, fl}, {26'b0, e[21:16]});
         end
      end
      if (accepted) expq.push_back(c);
   endtask

   task automatic stepn(input int n);
      bit a;
      repeat (n) step(a);
   endtask

   task automatic drive(input tcmd_t c);
      bus.s_valid     = 1'b1;
      bus.s_mode      = c.mode;
      bus.s_cmd       = c.cmd;
      bus.s_cin       = c.cin;
      bus.s_inp_valid = c.iv;
      bus.s_opa       = c.a;
      bus.s_opb       = c.b;
   endtask

   function automatic tcmd_t mk(logic mode, logic [3:0] cmd, logic [1:0] iv, logic [7:0] a, logic [7:0] b);
      tcmd_t c;
      c.mode = mode;  c.cmd = cmd;  c.cin = 1'($urandom_range(0, 1));
      c.iv = iv;  c.a = a;  c.b = b;
      return c;
   endfunction

   function automatic tcmd_t rand_cmd(bit allow_mul);
      tcmd_t c;
      c.mode = ($urandom_range(0, 3) != 0);
      c.cmd  = 4'($urandom_range(0, 15));
      if (!allow_mul && c.mode && (c.cmd == 4'd9 || c.cmd == 4'd10)) c.cmd = 4'd0;
      c.cin  = 1'($urandom_range(0, 1));
      c.iv   = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
      c.a    = 8'($urandom);
      c.b    = 8'($urandom);
      return c;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] held;
      int          sent;
      bit          saw;
      logic [15:0] exp_err;

      // Reset with a command offered
      bus.r_ready = 1'b0;
      drive(mk(1'b1, 4'd0, 2'b11, 8'd1, 8'd2));
      RST = 1'b0;
      stepn(2);
      chk("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
      chk("rst_ce", {31'b0, CE}, 32'd0);
      chk("rst_r_valid", {31'b0, bus.r_valid}, 32'd0);
      chk("rst_r_res_flags", {10'b0, bus.r_flags, bus.r_res}, 32'd0);
      chk("rst_alu_pins", {8'b0, INP_VALID, MODE, CMD, CIN, OPA, OPB}, 32'd0);
      chk("rst_err_count", {16'b0, err_count}, 32'd0);
      RST = 1'b1;
      bus.s_valid = 1'b0;
      #1;
      chk("post_rst_s_ready", {31'b0, bus.s_ready}, 32'd1);
      stepn(2);
      chk("post_rst_no_issue", {31'b0, CE}, 32'd0);
      chk("post_rst_empty", expq.size(), 0);

      // Single ADD: CE at c+2..c+3, r_valid at c+4
      drive(mk(1'b1, 4'd0, 2'b11, 8'd10, 8'd20));
      step(acc);
      chk("add_accept", {31'b0, acc}, 32'd1);
      bus.s_valid = 1'b0;
      chk("add_c1_ce", {31'b0, CE}, 32'd0);
      stepn(1);
      chk("add_c2_ce", {31'b0, CE}, 32'd1);
      chk("add_c2_ops", {16'b0, OPA, OPB}, {16'b0, 8'd10, 8'd20});
      stepn(1);
      chk("add_c3_ce", {31'b0, CE}, 32'd1);
      chk("add_c3_r_valid", {31'b0, bus.r_valid}, 32'd0);
      stepn(1);
      chk("add_c4_r_valid", {31'b0, bus.r_valid}, 32'd1);
      chk("add_c4_ce", {31'b0, CE}, 32'd0);
      chk("add_r_res", {16'b0, bus.r_res}, 32'd30);
      chk("add_r_flags", {26'b0, bus.r_flags}, 32'd0);
      bus.r_ready = 1'b1;
      stepn(1);
      chk("add_r_valid_drop", {31'b0, bus.r_valid}, 32'd0);
      bus.r_ready = 1'b0;

      // Multiply: CE for 3 cycles, r_valid at c+5
      drive(mk(1'b1, 4'd9, 2'b11, 8'd3, 8'd4));
      step(acc);
      bus.s_valid = 1'b0;
      stepn(1);
      chk("mul_c2_ce", {31'b0, CE}, 32'd1);
      stepn(1);
      chk("mul_c3_ce", {31'b0, CE}, 32'd1);
      stepn(1);
      chk("mul_c4_ce", {31'b0, CE}, 32'd1);
      chk("mul_c4_r_valid", {31'b0, bus.r_valid}, 32'd0);
      stepn(1);
      chk("mul_c5_r_valid", {31'b0, bus.r_valid}, 32'd1);
      chk("mul_c5_ce", {31'b0, CE}, 32'd0);
      chk("mul_r_res", {16'b0, bus.r_res}, 32'd20);
      bus.r_ready = 1'b1;
      stepn(1);
      bus.r_ready = 1'b0;

      // FIFO full with r_ready low, then in-order drain one result per 3 cycles
      for (int i = 0; i < 5; i++) begin
         drive(rand_cmd(1'b0));
         chk("fill_s_ready", {31'b0, bus.s_ready}, 32'd1);
         step(acc);
      end
      bus.s_valid = 1'b0;
      chk("full_s_ready", {31'b0, bus.s_ready}, 32'd0);
      for (int k = 0; k < 10 && bus.r_valid !== 1'b1; k++) stepn(1);
      chk("full_r_valid", {31'b0, bus.r_valid}, 32'd1);
      held = bus.r_res;
      stepn(3);
      chk("hold_r_res", {16'b0, bus.r_res}, {16'b0, held});
      chk("hold_r_valid", {31'b0, bus.r_valid}, 32'd1);
      chk("hold_s_ready", {31'b0, bus.s_ready}, 32'd0);
      hs_cyc.delete();
      bus.r_ready = 1'b1;
      for (int k = 0; k < 40 && expq.size() > 0; k++) stepn(1);
      chk("drain_empty", expq.size(), 0);
      chk("drain_count", hs_cyc.size(), 5);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("drain_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
      bus.r_ready = 1'b0;

      // Random commands and random back-pressure against the scoreboard
      sent = 0;
      got  = 0;
      for (int t = 0; t < 5000 && (sent < 60 || expq.size() > 0); t++) begin
         if (bus.s_valid !== 1'b1 && sent < 60 && $urandom_range(0, 2) != 0) drive(rand_cmd(1'b1));
         bus.r_ready = 1'($urandom_range(0, 1));
         step(acc);
         if (acc) begin
            sent++;
            bus.s_valid = 1'b0;
         end
      end
      chk("rand_sent", sent, 60);
      chk("rand_got", got, 60);
      chk("rand_empty", expq.size(), 0);
      bus.s_valid = 1'b0;
      bus.r_ready = 1'b0;
      stepn(2);

      // Reset during a multiply's WAIT drops everything
      drive(mk(1'b1, 4'd10, 2'b11, 8'($urandom), 8'($urandom)));
      step(acc);
      drive(rand_cmd(1'b0));
      step(acc);
      drive(rand_cmd(1'b0));
      step(acc);
      bus.s_valid = 1'b0;
      chk("midwait_ce", {31'b0, CE}, 32'd1);
      RST = 1'b0;
      stepn(1);
      chk("midrst_ce", {31'b0, CE}, 32'd0);
      chk("midrst_r_valid", {31'b0, bus.r_valid}, 32'd0);
      chk("midrst_s_ready", {31'b0, bus.s_ready}, 32'd0);
      chk("midrst_alu_pins", {8'b0, INP_VALID, MODE, CMD, CIN, OPA, OPB}, 32'd0);
      chk("midrst_err_count", {16'b0, err_count}, 32'd0);
      RST = 1'b1;
      expq.delete();
      bus.r_ready = 1'b1;
      saw = 1'b0;
      for (int k = 0; k < 15; k++) begin
         stepn(1);
         if (CE !== 1'b0 || bus.r_valid !== 1'b0) saw = 1'b1;
      end
      chk("midrst_nothing_issued", {31'b0, saw}, 32'd0);

      // Three CMP commands with INP_VALID=01 return ERR
      for (int i = 0; i < 3; i++) begin
         drive(mk(1'b1, 4'd8, 2'b01, 8'($urandom), 8'($urandom)));
         step(acc);
      end
      bus.s_valid = 1'b0;
      for (int k = 0; k < 40 && expq.size() > 0; k++) stepn(1);
      stepn(1);
      chk("err_drain_empty", expq.size(), 0);
`ifdef ALU_SCHED_ERRCNT_EN
      exp_err = 16'd3;
`else
      exp_err = 16'd0;
`endif
      chk("err_count", {16'b0, err_count}, {16'b0, exp_err});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
